// File: rtl/sbox_seq.sv
// sbox_seq: time-multiplexed DES substitution sequencer.
// Walks a 48-bit block through one shared S-box port, six bits per step
// (S1 first), and packs the eight 4-bit results into a 32-bit word.
module sbox_seq #(
  parameter bit REG_SBOX = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic [2:0]  sbox_sel,
  output logic [5:0]  sbox_in,
  input  logic [3:0]  sbox_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [47:0] shift_q, shift_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [3:0]  cap_cnt_q, cap_cnt_d;
  logic [31:0] result_q, result_d;
  logic        issued_q, issued_d;

  logic        issue_en;
  logic        cap_en;

  // Issue while fewer than eight chunks have gone out; capture either in the
  // same cycle (combinational bank) or one cycle after each issue (registered bank).
  always_comb begin
    issue_en = (state_q == ST_RUN) && !issue_cnt_q[3];
    cap_en   = REG_SBOX ? ((state_q == ST_RUN) && issued_q) : issue_en;
  end

  // State and datapath registers; reset discards any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      result_q    <= '0;
      issued_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      result_q    <= result_d;
      issued_q    <= issued_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    result_d    = result_q;
    issued_d    = issue_en;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shift_d     = in_data;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
          result_d    = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue_en) begin
          shift_d     = {shift_q[41:0], 6'b0};
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
        if (cap_en) begin
          result_d  = {result_q[27:0], sbox_out};
          cap_cnt_d = cap_cnt_q + 4'd1;
          if (cap_cnt_q == 4'd7) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; control outputs are held low while reset is asserted.
  always_comb begin
    in_ready  = !rst && (state_q == ST_IDLE);
    busy      = !rst && (state_q != ST_IDLE);
    out_valid = !rst && (state_q == ST_DONE);
    sbox_sel  = 3'd0;
    sbox_in   = 6'd0;
    if (!rst && issue_en) begin
      sbox_sel = issue_cnt_q[2:0];
      sbox_in  = shift_q[47:42];
    end
    out_data  = result_q;
  end

endmodule
